// File: rtl/level_tick_gen.sv
// Game-speed tick generator: one-cycle tick every 2^P(level) enabled cycles, with pause,
// deferred level loads applied on a wrap, and optional auto level-up.
module level_tick_gen #(
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned CNT_W      = 17,
  parameter int unsigned STEP       = 1,
  parameter int unsigned MIN_LOG2   = 12,
  parameter int unsigned ADV_TICKS  = 8,
  localparam int unsigned LVL_W     = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             lvl_load,
  input  logic [LVL_W-1:0] lvl_req,
  input  logic             auto_en,
  output logic             tick,
  output logic [LVL_W-1:0] level,
  output logic             lvl_max
);

  localparam int unsigned ADV_W = (ADV_TICKS > 2) ? $clog2(ADV_TICKS) : 1;
  localparam logic [LVL_W-1:0] MaxLvl  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [ADV_W-1:0] AdvLast = ADV_W'(ADV_TICKS - 1);

  // Terminal count 2^P(lvl)-1, with P clamped from below at MIN_LOG2.
  function automatic logic [CNT_W-1:0] wrap_val(input logic [LVL_W-1:0] lvl);
    int p;
    p = int'(CNT_W) - int'(lvl) * int'(STEP);
    if (p < int'(MIN_LOG2)) begin
      p = int'(MIN_LOG2);
    end
    return CNT_W'((64'd1 << p) - 64'd1);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LVL_W-1:0] pend_lvl_q, pend_lvl_d;
  logic             pend_vld_q, pend_vld_d;
  logic [ADV_W-1:0] adv_q, adv_d;

  logic [CNT_W-1:0] cnt_max;
  logic             at_wrap;
  logic [LVL_W-1:0] req_clamped;

  assign cnt_max     = wrap_val(level_q);
  assign at_wrap     = (cnt_q == cnt_max);
  assign req_clamped = (lvl_req > MaxLvl) ? MaxLvl : lvl_req;

  always_comb begin
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    level_d    = level_q;
    pend_lvl_d = pend_lvl_q;
    pend_vld_d = pend_vld_q;
    adv_d      = adv_q;

    if (enable) begin
      if (at_wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        // A pending load wins over auto advance on the same wrap.
        if (pend_vld_q) begin
          level_d    = pend_lvl_q;
          pend_vld_d = 1'b0;
          adv_d      = '0;
        end else if (auto_en) begin
          if (adv_q == AdvLast) begin
            adv_d = '0;
            if (level_q != MaxLvl) begin
              level_d = level_q + LVL_W'(1);
            end
          end else begin
            adv_d = adv_q + ADV_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (!auto_en) begin
      adv_d = '0;
    end

    // Captured after the wrap handling so a same-edge load stays pending for the next wrap.
    if (lvl_load) begin
      pend_lvl_d = req_clamped;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      level_q    <= '0;
      pend_lvl_q <= '0;
      pend_vld_q <= 1'b0;
      adv_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      level_q    <= level_d;
      pend_lvl_q <= pend_lvl_d;
      pend_vld_q <= pend_vld_d;
      adv_q      <= adv_d;
    end
  end

  assign tick    = tick_q;
  assign level   = level_q;
  assign lvl_max = (level_q == MaxLvl);

endmodule

// File: tb/tb_level_tick_gen.sv
// Bench for level_tick_gen (periods 64/32/16/8): scenario table plus tick-time scoreboard.
module tb_level_tick_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       lvl_load = 1'b0;
  logic [1:0] lvl_req = 2'd0;
  logic       auto_en = 1'b0;
  logic       tick;
  logic [1:0] level;
  logic       lvl_max;

  logic       lvl_load5 = 1'b0;
  logic [2:0] lvl_req5 = 3'd0;
  logic       tick5;
  logic [2:0] level5;
  logic       lvl_max5;

  int n_checks = 0;
  int n_fail = 0;
  int edge_n = 0;
  int exp_q[$];

  typedef struct {
    bit auto_on;
    int ld1_at;
    int ld1_req;
    int ld2_at;
    int ld2_req;
    int pause_at;
    int pause_len;
    int end_edge;
    int chk_at[6];
    int chk_lvl[6];
    int ticks[20];
  } scen_t;

  scen_t scen[5];

  always #5 clk = ~clk;

  level_tick_gen #(
    .NUM_LEVELS(4), .CNT_W(6), .STEP(1), .MIN_LOG2(3), .ADV_TICKS(3)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .lvl_load(lvl_load),
    .lvl_req (lvl_req),
    .auto_en (auto_en),
    .tick    (tick),
    .level   (level),
    .lvl_max (lvl_max)
  );

  // Five-level build so an out-of-range request can be driven.
  level_tick_gen #(
    .NUM_LEVELS(5), .CNT_W(6), .STEP(1), .MIN_LOG2(3), .ADV_TICKS(3)
  ) u_dut5 (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .lvl_load(lvl_load5),
    .lvl_req (lvl_req5),
    .auto_en (1'b0),
    .tick    (tick5),
    .level   (level5),
    .lvl_max (lvl_max5)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges, scoring every tick against the expected-edge queue.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      edge_n++;
      while (exp_q.size() > 0 && exp_q[0] < edge_n) begin
        n_checks++;
        n_fail++;
        $display("FAIL tick_missing: got no tick at edge %0d, expected tick", exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (tick) begin
        n_checks++;
        if (exp_q.size() > 0 && exp_q[0] == edge_n) begin
          void'(exp_q.pop_front());
        end else begin
          n_fail++;
          $display("FAIL tick_unexpected: got tick at edge %0d, expected none", edge_n);
        end
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_missing: got no tick at edge %0d, expected tick", exp_q[0]);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    lvl_load  = 1'b0;
    lvl_load5 = 1'b0;
    auto_en   = 1'b0;
    #1;
    chk("rst_tick", int'(tick), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_lvl_max", int'(lvl_max), 0);
    @(posedge clk);
    #1;
    drain();
    reset_n = 1'b1;
    edge_n  = 0;
  endtask

  initial begin
    scen[0] = '{auto_on: 1'b0, ld1_at: 0, ld1_req: 0, ld2_at: 0, ld2_req: 0,
                pause_at: 0, pause_len: 0, end_edge: 200,
                chk_at: '{0: 200, default: 0}, chk_lvl: '{default: 0},
                ticks: '{0: 64, 1: 128, 2: 192, default: 0}};
    scen[1] = '{auto_on: 1'b0, ld1_at: 11, ld1_req: 2, ld2_at: 0, ld2_req: 0,
                pause_at: 0, pause_len: 0, end_edge: 120,
                chk_at: '{0: 63, 1: 64, 2: 120, default: 0},
                chk_lvl: '{0: 0, 1: 2, 2: 2, default: 0},
                ticks: '{0: 64, 1: 80, 2: 96, 3: 112, default: 0}};
    scen[2] = '{auto_on: 1'b0, ld1_at: 5, ld1_req: 1, ld2_at: 20, ld2_req: 3,
                pause_at: 0, pause_len: 0, end_edge: 100,
                chk_at: '{0: 63, 1: 64, 2: 100, default: 0},
                chk_lvl: '{0: 0, 1: 3, 2: 3, default: 0},
                ticks: '{0: 64, 1: 72, 2: 80, 3: 88, 4: 96, default: 0}};
    scen[3] = '{auto_on: 1'b1, ld1_at: 0, ld1_req: 0, ld2_at: 0, ld2_req: 0,
                pause_at: 0, pause_len: 0, end_edge: 400,
                chk_at: '{191, 192, 287, 288, 336, 400},
                chk_lvl: '{0, 1, 1, 2, 3, 3},
                ticks: '{0: 64, 1: 128, 2: 192, 3: 224, 4: 256, 5: 288, 6: 304, 7: 320,
                         8: 336, 9: 344, 10: 352, 11: 360, 12: 368, 13: 376, 14: 384,
                         15: 392, 16: 400, default: 0}};
    scen[4] = '{auto_on: 1'b0, ld1_at: 36, ld1_req: 1, ld2_at: 0, ld2_req: 0,
                pause_at: 30, pause_len: 20, end_edge: 150,
                chk_at: '{0: 83, 1: 84, 2: 150, default: 0},
                chk_lvl: '{0: 0, 1: 1, 2: 1, default: 0},
                ticks: '{0: 84, 1: 116, 2: 148, default: 0}};

    #2;
    for (int s = 0; s < 5; s++) begin
      do_reset();
      auto_en = scen[s].auto_on;
      for (int t = 0; t < 20; t++) begin
        if (scen[s].ticks[t] > 0) exp_q.push_back(scen[s].ticks[t]);
      end
      for (int e = 1; e <= scen[s].end_edge; e++) begin
        lvl_load = (e == scen[s].ld1_at) || (e == scen[s].ld2_at);
        lvl_req  = 2'((e == scen[s].ld2_at) ? scen[s].ld2_req : scen[s].ld1_req);
        enable   = !(e > scen[s].pause_at && e <= scen[s].pause_at + scen[s].pause_len);
        step(1);
        for (int c = 0; c < 6; c++) begin
          if (scen[s].chk_at[c] == e) begin
            chk($sformatf("s%0d_level@%0d", s, e), int'(level), scen[s].chk_lvl[c]);
            chk($sformatf("s%0d_lvl_max@%0d", s, e), int'(lvl_max),
                (scen[s].chk_lvl[c] == 3) ? 1 : 0);
          end
        end
      end
      lvl_load = 1'b0;
      enable   = 1'b1;
      drain();
    end

    // Out-of-range request clamps to the top level of the five-level build.
    do_reset();
    enable   = 1'b1;
    lvl_req5 = 3'd7;
    exp_q.push_back(64);
    for (int e = 1; e <= 64; e++) begin
      lvl_load5 = (e == 5);
      step(1);
      if (e == 63) chk("clamp_level_before", int'(level5), 0);
    end
    chk("clamp_level", int'(level5), 4);
    chk("clamp_lvl_max", int'(lvl_max5), 1);
    chk("clamp_tick5", int'(tick5), 1);
    drain();

    // Load on the wrap edge stays pending; reset then discards it and drops tick at once.
    do_reset();
    enable = 1'b1;
    exp_q.push_back(64);
    step(63);
    lvl_load = 1'b1;
    lvl_req  = 2'd3;
    step(1);
    lvl_load = 1'b0;
    chk("same_edge_level", int'(level), 0);
    chk("same_edge_tick", int'(tick), 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_level", int'(level), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    edge_n  = 0;
    exp_q.push_back(64);
    exp_q.push_back(128);
    step(64);
    chk("discard_level", int'(level), 0);
    step(72);
    chk("discard_level_late", int'(level), 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
